// File: rtl/seq_det_pkg.sv
// Shared definitions for the time-multiplexed "1011" sequence detector.
//   det_state_e : 2-bit detector state (S0 nothing, S1 "1", S2 "10", S3 "101")
//   PATTERN     : the detected bit pattern, first bit in the MSB
//   seq_next    : one detector step, returns {next_state, match}
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_state_e;

    localparam logic [3:0] PATTERN = 4'b1011;

    // Overlapping Mealy step: a completed "1011" leaves the trailing "1" in S1.
    function automatic logic [2:0] seq_next(input det_state_e st, input logic b);
        logic [2:0] r;
        r = {S0, 1'b0};
        case (st)
            S0: r = b ? {S1, 1'b0} : {S0, 1'b0};
            S1: r = b ? {S1, 1'b0} : {S2, 1'b0};
            S2: r = b ? {S3, 1'b0} : {S0, 1'b0};
            S3: r = b ? {S1, 1'b1} : {S2, 1'b0};
            default: r = {S0, 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   ptr     : highest-priority channel this cycle
//   gnt     : one-hot grant (first requester at or after ptr, wrapping)
//   gnt_idx : index of the granted channel (0 when nothing granted)
//   any_gnt : a grant was issued
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx,
    output logic           any_gnt
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NCH;
            if (!any_gnt && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = CW'(idx);
                any_gnt  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One "1011" overlapping detector shared by NCH serial channels.
// A round-robin grant picks one channel per clock; its saved state is
// advanced by the granted bit and written back.
//   clock, reset : single clock, synchronous active-high reset
//   din_valid    : per-channel bit offered
//   din          : per-channel serial bit
//   din_ready    : one-hot grant, transfer when din_valid & din_ready
//   ch_clear     : per-channel force to S0 (blocks that channel's grant)
//   match_valid  : registered one-cycle pulse when a "1011" completes
//   match_ch     : channel of the match, valid with match_valid
//   busy_ch      : registered, per-channel saved state != S0
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] din_valid,
    input  logic [NCH-1:0] din,
    output logic [NCH-1:0] din_ready,
    input  logic [NCH-1:0] ch_clear,
    output logic           match_valid,
    output logic [CW-1:0]  match_ch,
    output logic [NCH-1:0] busy_ch
);

    det_state_e [NCH-1:0] state;
    det_state_e [NCH-1:0] state_d;
    logic [NCH-1:0]       req;
    logic [NCH-1:0]       gnt;
    logic [CW-1:0]        gnt_idx;
    logic                 any_gnt;
    logic [CW-1:0]        ptr;
    logic [CW-1:0]        ptr_next;
    logic [2:0]           step;
    logic                 hit;

    // A cleared channel never requests, so its bit stays with the sender.
    assign req = din_valid & ~ch_clear;

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign din_ready = reset ? '0 : gnt;

    // Only the granted channel's state goes through the shared step logic.
    assign step     = seq_next(state[gnt_idx], din[gnt_idx]);
    assign hit      = any_gnt & step[0];
    assign ptr_next = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d = state;
        for (int i = 0; i < NCH; i++) begin
            if (ch_clear[i])
                state_d[i] = S0;
            else if (gnt[i])
                state_d[i] = det_state_e'(step[2:1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) state[i] <= S0;
            ptr         <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            busy_ch     <= '0;
        end else begin
            state       <= state_d;
            if (any_gnt) ptr <= ptr_next;
            match_valid <= hit;
            match_ch    <= hit ? gnt_idx : '0;
            for (int i = 0; i < NCH; i++) busy_ch[i] <= (state_d[i] != S0);
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched (NCH = 4). A reference model of the
// detector table and round-robin order predicts din_ready in the same cycle
// and queues the registered outputs expected after each clock edge.
module tb_seq_det_sched;

    logic       clock;
    logic       reset;
    logic [3:0] din_valid;
    logic [3:0] din;
    logic [3:0] din_ready;
    logic [3:0] ch_clear;
    logic       match_valid;
    logic [1:0] match_ch;
    logic [3:0] busy_ch;

    seq_det_sched #(.NCH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready),
        .ch_clear    (ch_clear),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .busy_ch     (busy_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       mv;
        logic [1:0] mch;
        logic [3:0] busy;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp;
    int         n_bad;
    logic [1:0] m_st[4];
    int         m_ptr;
    int         cyc;
    logic       obs_mv;
    logic [1:0] obs_mch;
    int         obs_cnt[4];

    // Detector table written straight from the state list.
    function automatic logic [2:0] ref_next(input logic [1:0] s, input logic b);
        case (s)
            2'b00:   return b ? 3'b010 : 3'b000;
            2'b01:   return b ? 3'b010 : 3'b100;
            2'b10:   return b ? 3'b110 : 3'b000;
            default: return b ? 3'b011 : 3'b100;
        endcase
    endfunction

    // One clock: drive inputs, check din_ready and the outputs of the previous
    // edge at the falling edge, then queue the outputs expected after this edge.
    task automatic drive_cycle(input logic [3:0] v, input logic [3:0] d,
                               input logic [3:0] clr, input logic rst,
                               output logic [3:0] rdy);
        logic [3:0] req, eg;
        exp_t       e;
        int         g;
        logic [2:0] r;
        din_valid = v;
        din       = d;
        ch_clear  = clr;
        reset     = rst;
        req = v & ~clr;
        eg  = '0;
        g   = -1;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && req[idx]) begin
                    g = idx;
                    eg[idx] = 1'b1;
                end
            end
        end
        @(negedge clock);
        rdy = din_ready;
        n_cmp++;
        if (din_ready !== eg) begin
            n_bad++;
            $display("FAIL din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, eg);
        end
        obs_mv  = match_valid;
        obs_mch = match_ch;
        if (match_valid === 1'b1) obs_cnt[match_ch]++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (match_valid !== e.mv || (e.mv && match_ch !== e.mch) || busy_ch !== e.busy) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got mv=%b ch=%0d busy=%b exp mv=%b ch=%0d busy=%b",
                         cyc, match_valid, match_ch, busy_ch, e.mv, e.mch, e.busy);
            end
        end
        e.mv  = 1'b0;
        e.mch = 2'd0;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_st[i] = 2'b00;
            m_ptr = 0;
        end else begin
            if (g >= 0) begin
                r = ref_next(m_st[g], d[g]);
                m_st[g] = r[2:1];
                e.mv  = r[0];
                e.mch = 2'(g);
                m_ptr = (g + 1) % 4;
            end
            for (int i = 0; i < 4; i++) if (clr[i]) m_st[i] = 2'b00;
        end
        for (int i = 0; i < 4; i++) e.busy[i] = (m_st[i] != 2'b00);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Offer one bit on one channel until it is accepted (bounded).
    task automatic send(input int ch, input logic b);
        logic [3:0] v, d, rdy;
        int         n;
        logic       done;
        v = '0; v[ch] = 1'b1;
        d = '0; d[ch] = b;
        n = 0;
        done = 1'b0;
        while (!done && n < 20) begin
            drive_cycle(v, d, 4'b0000, 1'b0, rdy);
            n++;
            done = rdy[ch];
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_timeout ch=%0d got=no_grant exp=grant", ch);
        end
    endtask

    task automatic do_reset();
        logic [3:0] rdy;
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, rdy);
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, rdy);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (din_ready !== 4'b0000 || match_valid !== 1'b0 || busy_ch !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle got rdy=%b mv=%b busy=%b exp rdy=0000 mv=0 busy=0000",
                     din_ready, match_valid, busy_ch);
        end
    endtask

    task automatic test_single_overlap();
        logic [6:0] seq;
        logic [6:0] hits;
        logic [3:0] rdy;
        int         base;
        seq  = 7'b1011011;
        hits = '0;
        do_reset();
        base = obs_cnt[0];
        for (int j = 0; j < 7; j++) begin
            send(0, seq[6-j]);
            if (j > 0) hits[j-1] = obs_mv;
        end
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, rdy);
        hits[6] = obs_mv;
        n_cmp++;
        if (hits !== 7'b1001000) begin
            n_bad++;
            $display("FAIL single_match_bits got=%b exp=1001000", hits);
        end
        n_cmp++;
        if (obs_cnt[0] - base !== 2) begin
            n_bad++;
            $display("FAIL single_match_ch0 got=%0d exp=2", obs_cnt[0] - base);
        end
        n_cmp++;
        if (dut.state[0] !== 2'b01) begin
            n_bad++;
            $display("FAIL single_final_state got=%b exp=01", dut.state[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat, v, d, rdy;
        int         idx[4];
        int         glog[16];
        int         mcyc[$];
        int         mchs[$];
        logic       ok;
        pat = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) idx[i] = 0;
        for (int t = 0; t < 17; t++) begin
            for (int i = 0; i < 4; i++) begin
                v[i] = (idx[i] < 4);
                d[i] = v[i] ? pat[3-idx[i]] : 1'b0;
            end
            drive_cycle(v, d, 4'b0000, 1'b0, rdy);
            if (obs_mv) begin
                mcyc.push_back(t);
                mchs.push_back(int'(obs_mch));
            end
            if (t < 16) glog[t] = -1;
            for (int i = 0; i < 4; i++) begin
                if (rdy[i] && v[i]) begin
                    idx[i]++;
                    if (t < 16) glog[t] = i;
                end
            end
        end
        ok = 1'b1;
        for (int t = 0; t < 16; t++) if (glog[t] != t % 4) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rotate_order got first=%0d,%0d,%0d,%0d exp=0,1,2,3 repeating",
                     glog[0], glog[1], glog[2], glog[3]);
        end
        n_cmp++;
        if (mcyc.size() != 4) begin
            n_bad++;
            $display("FAIL all_match_count got=%0d exp=4", mcyc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (mcyc[k] != 13 + k || mchs[k] != k) begin
                    n_bad++;
                    $display("FAIL all_match_%0d got cyc=%0d ch=%0d exp cyc=%0d ch=%0d",
                             k, mcyc[k], mchs[k], 13 + k, k);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [2:0] s1;
        logic [1:0] s2;
        logic [3:0] v, d, rdy;
        int         i1, i2, n, b1, b2;
        s1 = 3'b101;
        s2 = 2'b11;
        do_reset();
        b1 = obs_cnt[1];
        b2 = obs_cnt[2];
        i1 = 0; i2 = 0; n = 0;
        while ((i1 < 3 || i2 < 2) && n < 20) begin
            v = '0; d = '0;
            if (i1 < 3) begin v[1] = 1'b1; d[1] = s1[2-i1]; end
            if (i2 < 2) begin v[2] = 1'b1; d[2] = s2[1-i2]; end
            drive_cycle(v, d, 4'b0000, 1'b0, rdy);
            if (rdy[1] && v[1]) i1++;
            if (rdy[2] && v[2]) i2++;
            n++;
        end
        send(1, 1'b1);
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, rdy);
        n_cmp++;
        if (obs_cnt[1] - b1 !== 1 || obs_cnt[2] - b2 !== 0) begin
            n_bad++;
            $display("FAIL interleave_matches got ch1=%0d ch2=%0d exp ch1=1 ch2=0",
                     obs_cnt[1] - b1, obs_cnt[2] - b2);
        end
        n_cmp++;
        if (dut.state[2] !== 2'b01 || dut.state[1] !== 2'b01) begin
            n_bad++;
            $display("FAIL interleave_states got ch1=%b ch2=%b exp ch1=01 ch2=01",
                     dut.state[1], dut.state[2]);
        end
    endtask

    task automatic test_clear();
        logic [3:0] rdy;
        int         b0;
        do_reset();
        send(0, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        b0 = obs_cnt[0];
        drive_cycle(4'b0001, 4'b0001, 4'b0001, 1'b0, rdy);
        n_cmp++;
        if (rdy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ready got=%b exp=0", rdy[0]);
        end
        n_cmp++;
        if (dut.state[0] !== 2'b00) begin
            n_bad++;
            $display("FAIL clear_state got=%b exp=00", dut.state[0]);
        end
        send(0, 1'b1);
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, rdy);
        n_cmp++;
        if (obs_cnt[0] - b0 !== 0) begin
            n_bad++;
            $display("FAIL clear_nomatch got=%0d exp=0", obs_cnt[0] - b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] rdy;
        int         b3;
        do_reset();
        send(3, 1'b1);
        send(3, 1'b0);
        send(3, 1'b1);
        b3 = obs_cnt[3];
        drive_cycle(4'b1000, 4'b1000, 4'b0000, 1'b1, rdy);
        drive_cycle(4'b0000, 4'b0000, 4'b0000, 1'b0, rdy);
        n_cmp++;
        if (obs_cnt[3] - b3 !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_nomatch got=%0d exp=0", obs_cnt[3] - b3);
        end
        n_cmp++;
        if (dut.state !== 8'h00 || busy_ch !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_mid_states got=%b busy=%b exp=00000000 busy=0000",
                     dut.state, busy_ch);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        m_ptr = 0;
        obs_mv  = 1'b0;
        obs_mch = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_st[i]    = 2'b00;
            obs_cnt[i] = 0;
        end
        reset     = 1'b1;
        din_valid = '0;
        din       = '0;
        ch_clear  = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_single_overlap();
        test_back_to_back();
        test_interleave();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
